// File: rtl/max_finder_unit.sv
`default_nettype none
// ============================================================================
// Module   : max_finder_unit
// Brief    : Streaming peak detector; tracks the largest sample since the last
//            start/reset together with the position it arrived with.
// Revision : 1.0 - initial release
// ============================================================================
module max_finder_unit #(
    parameter int DATA_W = 8,
    parameter int POS_W  = 9
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [POS_W-1:0]  data_pos,
    output logic [POS_W-1:0]  max_pos,
    output logic [DATA_W-1:0] max_value,
    output logic              max_found
);

    logic [DATA_W-1:0] r_max_value;
    logic [POS_W-1:0]  r_max_pos;
    logic              r_max_found;
    logic              w_take;

    // The first sample after a clear is taken even if it is zero; afterwards
    // only a strictly larger value wins, so ties keep the earlier position.
    assign w_take = data_valid && (!r_max_found || (data_in > r_max_value));

    always_ff @(posedge clk_in) begin
        if (rst_in || start) begin
            r_max_value <= '0;
            r_max_pos   <= '0;
            r_max_found <= 1'b0;
        end else if (w_take) begin
            r_max_value <= data_in;
            r_max_pos   <= data_pos;
            r_max_found <= 1'b1;
        end
    end

    assign max_value = r_max_value;
    assign max_pos   = r_max_pos;
    assign max_found = r_max_found;

endmodule
`default_nettype wire

// File: tb/tb_max_finder_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_finder_unit
// Brief    : Self-checking bench for max_finder_unit: directed scenarios plus
//            randomized traffic against a sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_finder_unit;

    localparam int DATA_W = 8;
    localparam int POS_W  = 9;

    logic              clk_in;
    logic              rst_in;
    logic              start;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic [POS_W-1:0]  data_pos;
    logic [POS_W-1:0]  max_pos;
    logic [DATA_W-1:0] max_value;
    logic              max_found;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [DATA_W-1:0] v;
        logic [POS_W-1:0]  p;
    } samp_t;

    // Every sample accepted since the last clear, in arrival order.
    samp_t hist[$];

    max_finder_unit #(.DATA_W(DATA_W), .POS_W(POS_W)) u_dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start      (start),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_pos   (data_pos),
        .max_pos    (max_pos),
        .max_value  (max_value),
        .max_found  (max_found)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, update the model at the edge, compare after it.
    task automatic drive(input logic r, input logic s, input logic v,
                         input logic [DATA_W-1:0] d, input logic [POS_W-1:0] p);
        logic [DATA_W-1:0] e_val;
        logic [POS_W-1:0]  e_pos;
        logic              e_fnd;
        rst_in     = r;
        start      = s;
        data_valid = v;
        data_in    = d;
        data_pos   = p;
        @(posedge clk_in);
        if (r || s) hist.delete();
        else if (v) hist.push_back('{v: d, p: p});
        e_val = '0;
        e_pos = '0;
        e_fnd = (hist.size() != 0);
        if (e_fnd) begin
            e_val = hist[0].v;
            e_pos = hist[0].p;
            foreach (hist[i]) begin
                if (hist[i].v > e_val) begin
                    e_val = hist[i].v;
                    e_pos = hist[i].p;
                end
            end
        end
        #1;
        chk("max_value", 32'(max_value), 32'(e_val));
        chk("max_pos",   32'(max_pos),   32'(e_pos));
        chk("max_found", 32'(max_found), 32'(e_fnd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_in     = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        data_pos   = '0;

        // Reset then idle
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rst_value", 32'(max_value), 32'd0);
        chk("rst_found", 32'(max_found), 32'd0);
        idle(3);
        chk("idle_pos", 32'(max_pos), 32'd0);

        // Basic scan
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, '0, '0);
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 8'd0, 9'd0);
        chk("scan_first_found", 32'(max_found), 32'd1);
        for (int i = 0; i < 14; i++) drive(1'b0, 1'b0, 1'b1, 8'd0, 9'd0);
        drive(1'b0, 1'b0, 1'b1, 8'd100, 9'd123);
        chk("scan_100_val", 32'(max_value), 32'd100);
        chk("scan_100_pos", 32'(max_pos), 32'd123);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 1'b1, 8'd100, 9'd123);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8'd110, 9'd130);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 8'd90, 9'd140);
        chk("scan_keep_val", 32'(max_value), 32'd110);
        chk("scan_keep_pos", 32'(max_pos), 32'd130);

        // Tie keeps earlier position
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b1, 8'd50, 9'd10);
        drive(1'b0, 1'b0, 1'b1, 8'd50, 9'd20);
        chk("tie_pos", 32'(max_pos), 32'd10);

        // Zero as first sample
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b1, 8'd0, 9'd7);
        chk("zero_found", 32'(max_found), 32'd1);
        chk("zero_pos", 32'(max_pos), 32'd7);

        // Restart mid-scan discards the coincident sample
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b1, 8'd200, 9'd5);
        drive(1'b0, 1'b1, 1'b1, 8'd255, 9'd6);
        chk("restart_found", 32'(max_found), 32'd0);
        chk("restart_value", 32'(max_value), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 8'd30, 9'd9);
        chk("restart_val2", 32'(max_value), 32'd30);
        chk("restart_pos2", 32'(max_pos), 32'd9);

        // Gating and maximum code
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, 8'd255, 9'd100);
        chk("gate_found", 32'(max_found), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 8'd255, 9'd511);
        drive(1'b0, 1'b0, 1'b1, 8'd255, 9'd3);
        drive(1'b0, 1'b0, 1'b1, 8'd10, 9'd2);
        chk("maxcode_val", 32'(max_value), 32'd255);
        chk("maxcode_pos", 32'(max_pos), 32'd511);

        // Reset mid-scan
        drive(1'b1, 1'b0, 1'b1, 8'd1, 9'd1);
        chk("midrst_value", 32'(max_value), 32'd0);

        // Randomized traffic; narrow data ranges provoke ties and repeats
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic s;
            logic v;
            logic [DATA_W-1:0] d;
            r = ($urandom_range(0, 79) == 0);
            s = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 7))
                                            : DATA_W'($urandom);
            drive(r, s, v, d, POS_W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/max_finder_unit.md
# max_finder_unit

Streaming peak detector for one line of 8-bit sensor samples. It tracks the largest sample value seen since the last `start` pulse, together with the pixel position that sample was presented with. It sits between the sensor pixel readout and the downstream peak/position logic, which reads `max_value`/`max_pos` once the line has been scanned. Module name: `max_finder_unit`.

## Interface
Parameters:
- `DATA_W`, default 8: sample width.
- `POS_W`, default 9: position width.

Ports (one clock; reset is synchronous and active-high):
- `clk_in`  in  1  system clock; all logic on its rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new search; clears the tracked maximum. Level-sensitive, may be held for several cycles.
- `data_valid`  in  1  qualifies `data_in`/`data_pos` in the current cycle.
- `data_in`  in  DATA_W  sample value (unsigned).
- `data_pos`  in  POS_W  position tag of `data_in`.
- `max_pos`  out  POS_W  position of the current maximum.
- `max_value`  out  DATA_W  current maximum value.
- `max_found`  out  1  high once at least one sample has been accepted since the last `start`/reset.

## Operation
- Internal state: `max_value`, `max_pos`, `max_found` registers.
- Priority per cycle, highest first: `rst_in`, then `start`, then `data_valid`.
- `rst_in`=1: `max_value`=0, `max_pos`=0, `max_found`=0.
- `start`=1 (no reset): `max_value`=0, `max_pos`=0, `max_found`=0. Any `data_valid` sample in the same cycle is discarded.
- `data_valid`=1 with `max_found`=0: the sample is loaded unconditionally (`max_value`=`data_in`, `max_pos`=`data_pos`) and `max_found` is set to 1. This rule also applies when `data_in`=0.
- `data_valid`=1 with `max_found`=1: the registers update only if `data_in` > `max_value` (strict unsigned compare).
  - On a tie, the earlier position is kept.
  - A repeated identical sample causes no change.
- `data_valid`=0: registers hold.
- `data_pos` is not checked: it is not required to be monotonic or unique, and it is stored verbatim.
- No saturation or overflow is possible. Outputs are direct register outputs.

## Timing
- Latency: 1 clock. A sample accepted at edge N is visible on the outputs after edge N, i.e. during cycle N+1.
- Reset and `start` both take effect at the next rising edge. Outputs are 0/0/0 from that edge on, and stay so while `start` is held.
- Throughput: one sample per clock, with no back-pressure.
- `start` during a scan clears the result immediately. The search restarts with the first valid sample after `start` deasserts.
- Reset asserted mid-scan: same effect as `start`. Outputs are 0 from the next edge.
- Outputs are stable between accepted updates. There is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: assert `rst_in` for 2 cycles with `data_valid`=0. Required: `max_value`=0, `max_pos`=0, `max_found`=0, holding while idle.
- Basic scan:
  - Stimulus: `start` for 3 cycles, 3 idle cycles, then `data_valid`=1 with 0@0 for 15 cycles, then 100@123, 110@130 and 90@140, each held for 3 cycles.
  - Required: 0/0 with found=1 after the first valid edge; 100/123 one cycle after the first 100 sample; 110/130 one cycle after the first 110 sample; 110/130 retained through the 90 samples.
- Tie: after `start`, feed 50@10 then 50@20. Required: `max_pos`=10.
- Zero/first-sample rule: after `start`, feed 0@7. Required: `max_found`=1, `max_pos`=7.
- Restart mid-scan:
  - Stimulus: reach 200@5, then assert `start` for 1 cycle with `data_valid`=1 and 255@6, then feed 30@9.
  - Required: outputs 0/0/found=0 after the `start` edge (255 discarded), then 30/9.
- Gating and max code: `data_valid`=0 with `data_in`=255 changes nothing; with valid=1, 255@511 is captured and all later samples are ignored.
